// File: rtl/l2_flush_walker.sv
// L2 flush sequencer: walks every set/way, issues writeback/invalidate commands to the
// eviction path and drives the flush/MSHR status-register triggers.
module l2_flush_walker #(
   parameter int SET_BITS     = 8,
   parameter int WAY_BITS     = 3,
   parameter int N_MSHR       = 16,
   parameter int MSHR_BITS_P1 = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush_req_valid,
   output logic                    flush_req_ready,
   input  logic                    flush_req_inv,
   input  logic                    ongoing_flush,
   input  logic [SET_BITS:0]       flush_set,
   input  logic [WAY_BITS:0]       flush_way,
   input  logic [MSHR_BITS_P1-1:0] mshr_cnt,
   output logic                    set_ongoing_flush,
   output logic                    clr_ongoing_flush,
   output logic                    clr_flush_set,
   output logic                    incr_flush_set,
   output logic                    clr_flush_way,
   output logic                    incr_flush_way,
   output logic                    lookup_valid,
   output logic [SET_BITS-1:0]     lookup_set,
   output logic [WAY_BITS-1:0]     lookup_way,
   input  logic                    lookup_rsp_valid,
   input  logic                    lookup_line_valid,
   input  logic                    lookup_dirty,
   output logic                    evict_valid,
   input  logic                    evict_ready,
   output logic [SET_BITS-1:0]     evict_set,
   output logic [WAY_BITS-1:0]     evict_way,
   output logic                    evict_wb,
   output logic                    evict_inv,
   output logic                    flush_busy,
   output logic                    flush_done
);

   typedef enum logic [2:0] {IDLE, INIT, LOOKUP, WAIT_RSP, EVICT, NEXT, DRAIN} state_t;

   state_t state;
   logic   inv_q;
   logic   need_wb;
   logic   need_inv;
   logic   evict_hold;
   logic   next_clr_way;
   logic   accept;
   logic   way_last;
   logic   set_last;
   logic   mshr_free;
   logic   rsp_evict;
   logic   evict_fire;
   logic   leave_line;

   assign flush_req_ready = (state == IDLE) && !ongoing_flush;
   assign accept          = rst && flush_req_valid && flush_req_ready;
   assign way_last        = &flush_way[WAY_BITS-1:0];
   assign set_last        = &flush_set[SET_BITS-1:0];
   assign mshr_free       = (mshr_cnt == MSHR_BITS_P1'(N_MSHR));
   assign rsp_evict       = lookup_line_valid && (lookup_dirty || inv_q);

   // Once raised, evict_valid is held even if the MSHR count drops back to zero.
   assign evict_valid = (state == EVICT) && ((mshr_cnt != '0) || evict_hold);
   assign evict_fire  = evict_valid && evict_ready;
   assign leave_line  = ((state == WAIT_RSP) && lookup_rsp_valid && !rsp_evict) || evict_fire;

   assign lookup_set = lookup_valid ? flush_set[SET_BITS-1:0] : '0;
   assign lookup_way = lookup_valid ? flush_way[WAY_BITS-1:0] : '0;
   assign evict_set  = (state == EVICT) ? flush_set[SET_BITS-1:0] : '0;
   assign evict_way  = (state == EVICT) ? flush_way[WAY_BITS-1:0] : '0;
   assign evict_wb   = (state == EVICT) && need_wb;
   assign evict_inv  = (state == EVICT) && need_inv;

   // Accept and drain-complete pulses must land in the same cycle as their qualifying input.
   assign set_ongoing_flush = accept;
   assign clr_flush_set     = accept;
   assign clr_flush_way     = accept || next_clr_way;
   assign flush_done        = (state == DRAIN) && mshr_free;
   assign clr_ongoing_flush = flush_done;
   assign flush_busy        = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         inv_q          <= 1'b0;
         need_wb        <= 1'b0;
         need_inv       <= 1'b0;
         evict_hold     <= 1'b0;
         lookup_valid   <= 1'b0;
         next_clr_way   <= 1'b0;
         incr_flush_way <= 1'b0;
         incr_flush_set <= 1'b0;
      end else begin
         lookup_valid   <= 1'b0;
         // Counter stepping is decided on leaving a line, so the pulse is out during NEXT.
         incr_flush_way <= leave_line && !way_last;
         incr_flush_set <= leave_line && way_last;
         next_clr_way   <= leave_line && way_last;
         evict_hold     <= evict_valid && !evict_ready;
         case (state)
            IDLE: begin
               if (accept) begin
                  inv_q <= flush_req_inv;
                  state <= INIT;
               end
            end
            INIT: begin
               state        <= LOOKUP;
               lookup_valid <= 1'b1;
            end
            LOOKUP: state <= WAIT_RSP;
            WAIT_RSP: begin
               if (lookup_rsp_valid) begin
                  need_wb  <= lookup_line_valid && lookup_dirty;
                  need_inv <= lookup_line_valid && inv_q;
                  state    <= rsp_evict ? EVICT : NEXT;
               end
            end
            EVICT: begin
               if (evict_fire) state <= NEXT;
            end
            NEXT: begin
               if (way_last && set_last) begin
                  state <= DRAIN;
               end else begin
                  state        <= LOOKUP;
                  lookup_valid <= 1'b1;
               end
            end
            DRAIN: begin
               if (mshr_free) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/l2_flush_walker.md
# l2_flush_walker

Sequencer that walks every L2 set/way during a flush and issues writebacks/invalidations to the eviction path. It is the trigger source for the L2 flush/MSHR status registers: it pulses the set/clear/increment triggers and reads back the registered `ongoing_flush`, `flush_set`, `flush_way` and `mshr_cnt`. It sits between the L2 front-end flush request and the tag/state array plus eviction path.

## Interface
- `SET_BITS`, 8, L2 set index width (sets = 2^SET_BITS).
- `WAY_BITS`, 3, L2 way index width (ways = 2^WAY_BITS).
- `N_MSHR`, 16, MSHR entries; `mshr_cnt == N_MSHR` means all free.
- `MSHR_BITS_P1`, 5, width of `mshr_cnt`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `flush_req_valid` in 1 / `flush_req_ready` out 1: flush request handshake.
- `flush_req_inv` in 1: 1 = write back dirty lines and invalidate all valid lines; 0 = write back dirty lines only.
- `ongoing_flush` in 1; `flush_set` in SET_BITS+1; `flush_way` in WAY_BITS+1; `mshr_cnt` in MSHR_BITS_P1: registered status.
- `set_ongoing_flush`, `clr_ongoing_flush`, `clr_flush_set`, `incr_flush_set`, `clr_flush_way`, `incr_flush_way` out 1 each: single-cycle trigger pulses.
- `lookup_valid` out 1; `lookup_set` out SET_BITS; `lookup_way` out WAY_BITS: tag/state read request.
- `lookup_rsp_valid` in 1; `lookup_line_valid` in 1; `lookup_dirty` in 1: read response.
- `evict_valid` out 1 / `evict_ready` in 1; `evict_set` out SET_BITS; `evict_way` out WAY_BITS; `evict_wb` out 1; `evict_inv` out 1: eviction command.
- `flush_busy` out 1; `flush_done` out 1 (pulse).

## Operation
- States: IDLE, INIT, LOOKUP, WAIT_RSP, EVICT, NEXT, DRAIN.
- IDLE: `flush_req_ready = !ongoing_flush`. On `valid && ready`: latch `inv_q = flush_req_inv`; pulse `set_ongoing_flush`, `clr_flush_set`, `clr_flush_way`; go to INIT.
- INIT: one cycle, so the status registers show cleared counters; go to LOOKUP.
- LOOKUP: pulse `lookup_valid` with `lookup_set = flush_set[SET_BITS-1:0]` and `lookup_way = flush_way[WAY_BITS-1:0]`; go to WAIT_RSP.
- WAIT_RSP: hold until `lookup_rsp_valid`. Set `need_wb = line_valid && dirty` and `need_inv = line_valid && inv_q`. If `need_wb || need_inv`, latch both and go to EVICT; otherwise go to NEXT.
- EVICT: `evict_valid = (mshr_cnt != 0)`; `evict_set`/`evict_way` come from the current counters, `evict_wb = need_wb`, `evict_inv = need_inv`.
  - While `mshr_cnt == 0`, `evict_valid` stays low and the FSM stalls.
  - Once asserted, `evict_valid` and its payload hold stable until `evict_ready`; then go to NEXT.
- NEXT:
  - If `flush_way[WAY_BITS-1:0]` is all ones: pulse `clr_flush_way` and `incr_flush_set`. If `flush_set[SET_BITS-1:0]` is also all ones, go to DRAIN; otherwise go to LOOKUP.
  - Otherwise: pulse `incr_flush_way` and go to LOOKUP.
- DRAIN: wait for `mshr_cnt == N_MSHR`, then pulse `clr_ongoing_flush` and `flush_done` together; go to IDLE.
- `flush_busy = (state != IDLE)`.
- The block never asserts a clear and an increment for the same counter in one cycle, and never asserts `set_ongoing_flush` and `clr_ongoing_flush` together.
- `flush_req_valid` outside IDLE is ignored (ready low); the request is not queued.

## Timing
- Reset: state = IDLE, `inv_q`/`need_wb`/`need_inv` = 0. All outputs 0 except `flush_req_ready`, which is combinational `!ongoing_flush`.
- Asserting `rst` mid-walk aborts immediately with no trigger pulses. The status registers are reset by the same `rst`.
- Trigger pulses last exactly one cycle. Their effect is visible on the status inputs in the following cycle; NEXT→LOOKUP relies on this.
- A clean line costs LOOKUP + WAIT_RSP + NEXT = 3 cycles minimum with a zero-wait response (response the cycle after `lookup_valid`).
- An evicted line costs 4 cycles minimum (`evict_ready` high in the EVICT entry cycle).
- The last line's NEXT goes to DRAIN; DRAIN completes in 1 cycle if MSHRs are already free.
- Accept to `flush_done`, minimum: 1 (IDLE) + 1 (INIT) + 3·sets·ways + 1 (DRAIN).

## Test plan
- SET_BITS=2, WAY_BITS=1, N_MSHR=4; all lines invalid; request with `inv=0` and 1-cycle lookup latency:
  - exactly 8 lookups, in order (0,0),(0,1),(1,0)…(3,1);
  - no `evict_valid`;
  - `flush_done` 27 cycles after accept.
- Line (2,1) valid+dirty, `inv=0` → one eviction at set 2, way 1 with `wb=1`, `inv=0`; all other lines skipped; `incr_flush_set` pulses exactly 4 times.
- All lines valid and clean, `inv=1` → 8 evictions, each with `wb=0`, `inv=1`.
- `mshr_cnt=0` on entry to EVICT for 10 cycles:
  - `evict_valid` stays low 10 cycles, then rises;
  - with `evict_ready` low for 3 cycles, the payload stays stable.
- After the last line, `mshr_cnt=2` → FSM holds in DRAIN; when `mshr_cnt` becomes 4, `clr_ongoing_flush` and `flush_done` pulse in the same cycle.
- `rst` low during WAIT_RSP of line (1,0) → all outputs 0 next cycle; a new request after reset starts again at (0,0).
